aes256_key_schedule_iter: RTL and testbench
===========================================

Name: aes256_key_schedule_iter

Overview:
Iterative AES-256 key schedule sequencer. It accepts one 256-bit cipher key and streams the 15 round keys RK0..RK14 (128 bits each) to the downstream round datapath over a valid/ready interface. The block holds the two most recent half-keys, computes each next half-key with one shared 4-byte S-box word stage, and tracks Rcon and round index internally. It sits between the key input and the cipher round engine.

Parameters:
SBOX_REG, 0, 1 inserts a register after the SubWord stage. Each generated round key then takes 2 cycles (adds state CALC). 0 means fully combinational next-key generation.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
key_valid  input  1  key offer
key_ready  output  1  block can accept a key (high only in IDLE)
key  input  256  cipher key; key[255:128] = RK0, key[127:0] = RK1
rk_valid  output  1  round key presented
rk_ready  input  1  downstream accepts round key
rk_data  output  128  round key; word0 = bits [127:96]
rk_idx  output  4  index of rk_data, 0..14
rk_last  output  1  high with rk_valid when rk_idx == 14
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (rst high at a clock edge): state = IDLE, rk_valid = 0, rk_data = 0, rk_idx = 0, rk_last = 0, busy = 0, rcon = 8'h01. key_ready = 1 from the first cycle after rst is deasserted. Reset mid-stream abandons the stream with no further beats.
- State IDLE: key_ready = 1. On key_valid & key_ready:
  - prev <= key[255:128], curr <= key[127:0], idx <= 0, rcon <= 8'h01.
  - Go to EMIT. rk_valid rises in the next cycle (1-cycle latency).
- State EMIT: rk_valid = 1, rk_data = prev, rk_idx = idx, rk_last = (idx == 14).
  - rk_data, rk_idx and rk_last are held stable while rk_valid & !rk_ready.
  - On the handshake with idx == 14: go to IDLE, rk_valid = 0 next cycle.
  - On the handshake with idx < 14 and SBOX_REG = 0: prev <= curr, curr <= next, idx <= idx+1. Stay in EMIT, so back-to-back beats are possible.
  - On the handshake with idx < 14 and SBOX_REG = 1: register temp and go to CALC (rk_valid = 0).
- State CALC (SBOX_REG = 1 only): prev <= curr, curr <= next using the registered temp, idx <= idx+1, go to EMIT.
- Next half-key generation, for j = idx+2 (the index being generated, only when j <= 14; computation for j > 14 is suppressed):
  - w3 = curr[31:0].
  - Even j: temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}. RotWord rotates left by 8 bits (MSB byte moves to LSB). rcon <= xtime(rcon) after use.
  - Odd j: temp = SubWord(w3). rcon is unchanged.
  - n0 = prev.w0 ^ temp, n1 = prev.w1 ^ n0, n2 = prev.w2 ^ n1, n3 = prev.w3 ^ n2. next = {n0, n1, n2, n3}.
  - Rcon values used for j = 2, 4, ..., 14: 01, 02, 04, 08, 10, 20, 40.
- SubWord uses four instances of the codebase aes_sbox byte S-box.
- key_ready is 0 whenever busy = 1. key_valid offered during a stream is ignored and not captured.
- There is one bubble cycle between the last beat of one stream and acceptance of the next key.
- Throughput: SBOX_REG = 0 gives 15 beats in 15 cycles with rk_ready held high. SBOX_REG = 1 gives 15 beats in 29 cycles.
- rk_ready high while rk_valid = 0 has no effect.

Test Plan:
- FIPS-197 A.3 key 603deb10...0914dff4, rk_ready = 1, SBOX_REG = 0 -> RK0 = 603deb1015ca71be2b73aef0857d7781, RK1 = 1f352c073b6108d72d9810a30914dff4, RK2 = 9ba354118e6925afa51a8b5f2067fcde, RK3 = a8b09c1a93d194cdbe49846eb75d5b9a, RK14 = fe4890d1e6188d0b046df344706c631e with rk_last = 1. rk_valid is high for exactly 15 consecutive cycles.
- Same key with rk_ready toggling randomly -> identical 15-key sequence. rk_data and rk_idx are stable through every stall.
- SBOX_REG = 1, same key -> identical keys, rk_valid low for one cycle between beats, last beat at cycle 29 after acceptance.
- Assert key_valid with a different key during the stream -> it is not accepted (key_ready = 0) and the stream is unaffected. The second key is accepted in the cycle after the return to IDLE, with RK0 = its upper half.
- rst asserted at rk_idx = 7 -> next cycle rk_valid = 0, busy = 0. A new key after reset streams correctly from RK0 (verifies the rcon reset).
- All-zero key -> RK2 = 62636363626363636263636362636363, RK3 = aafbfbfbaafbfbfbaafbfbfbaafbfbfb.

Source files
------------

// File: rtl/aes256_key_schedule_iter.sv
// Iterative AES-256 key schedule: streams round keys RK0..RK14 over valid/ready,
// generating one 128-bit half-key per step from a shared 4-byte SubWord stage.
module aes256_key_schedule_iter #(
  parameter int SBOX_REG = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EMIT, CALC} state_t;

  state_t       r_state;
  state_t       w_nextState;
  logic [127:0] r_prev;
  logic [127:0] r_curr;
  logic [3:0]   r_idx;
  logic [7:0]   r_rcon;
  logic [31:0]  r_temp;

  logic         w_load;
  logic         w_advance;
  logic         w_capture;
  logic         w_even;
  logic         w_suppress;
  logic         w_rconStep;
  logic [7:0]   w_rconNext;
  logic [31:0]  w_w3;
  logic [31:0]  w_subIn;
  logic [31:0]  w_subOut;
  logic [31:0]  w_tempComb;
  logic [31:0]  w_tempUse;
  logic [31:0]  w_n0;
  logic [31:0]  w_n1;
  logic [31:0]  w_n2;
  logic [31:0]  w_n3;
  logic [127:0] w_next;

  // The half-key being generated has index idx+2, so an even idx means an even j
  assign w_even     = ~r_idx[0];
  assign w_suppress = (r_idx > 4'd12);
  assign w_w3       = r_curr[31:0];
  assign w_subIn    = w_even ? {w_w3[23:0], w_w3[31:24]} : w_w3;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .i_in  (w_subIn[8*b +: 8]),
      .o_out (w_subOut[8*b +: 8])
    );
  end

  assign w_tempComb = w_even ? (w_subOut ^ {r_rcon, 24'h000000}) : w_subOut;
  assign w_tempUse  = (SBOX_REG != 0) ? r_temp : w_tempComb;

  assign w_n0   = r_prev[127:96] ^ w_tempUse;
  assign w_n1   = r_prev[95:64]  ^ w_n0;
  assign w_n2   = r_prev[63:32]  ^ w_n1;
  assign w_n3   = r_prev[31:0]   ^ w_n2;
  assign w_next = {w_n0, w_n1, w_n2, w_n3};

  assign w_rconNext = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
  // Rcon advances exactly when it has been folded into a temp word
  assign w_rconStep = w_even & ~w_suppress &
                      (w_capture | (w_advance & (SBOX_REG == 0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    key_ready   = 1'b0;
    rk_valid    = 1'b0;
    busy        = 1'b1;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        key_ready = 1'b1;
        busy      = 1'b0;
        if (key_valid) begin
          w_load      = 1'b1;
          w_nextState = EMIT;
        end
      end
      EMIT: begin
        rk_valid = 1'b1;
        if (rk_ready) begin
          if (r_idx == 4'd14) begin
            w_nextState = IDLE;
          end else if (SBOX_REG == 0) begin
            w_advance = 1'b1;
          end else begin
            w_capture   = 1'b1;
            w_nextState = CALC;
          end
        end
      end
      CALC: begin
        w_advance   = 1'b1;
        w_nextState = EMIT;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign rk_data = r_prev;
  assign rk_idx  = r_idx;
  assign rk_last = rk_valid & (r_idx == 4'd14);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      r_curr <= '0;
      r_idx  <= 4'd0;
      r_rcon <= 8'h01;
      r_temp <= '0;
    end else if (w_load) begin
      r_prev <= key[255:128];
      r_curr <= key[127:0];
      r_idx  <= 4'd0;
      r_rcon <= 8'h01;
    end else begin
      if (w_capture) begin
        r_temp <= w_tempComb;
      end
      if (w_rconStep) begin
        r_rcon <= w_rconNext;
      end
      if (w_advance) begin
        r_prev <= r_curr;
        r_idx  <= r_idx + 4'd1;
        if (!w_suppress) begin
          r_curr <= w_next;
        end
      end
    end
  end

endmodule

// AES forward S-box: multiplicative inverse in GF(2^8) (as x^254) then the affine map.
module aes_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] w_inv;

  // x^254 = product of x^(2^k) for k = 1..7; zero maps to zero naturally
  always_comb begin
    logic [7:0] sq;
    sq    = i_in;
    w_inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq    = gfMul(sq, sq);
      w_inv = gfMul(w_inv, sq);
    end
  end

  assign o_out = w_inv
               ^ {w_inv[6:0], w_inv[7]}
               ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]}
               ^ {w_inv[3:0], w_inv[7:4]}
               ^ 8'h63;

endmodule

// File: tb/tb_aes256_key_schedule_iter.sv
// Directed bench for aes256_key_schedule_iter; instance 0 uses SBOX_REG=0,
// instance 1 uses SBOX_REG=1, both checked against FIPS-197 round keys.
module tb_aes256_key_schedule_iter;

  localparam logic [255:0] KEY_FIPS =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_ZERO = 256'h0;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] key;
  logic [1:0]   keyValid;
  logic [1:0]   rkReady;
  logic [1:0]   keyReady;
  logic [1:0]   rkValid;
  logic [1:0]   rkLast;
  logic [1:0]   busy;
  logic [127:0] rkData [2];
  logic [3:0]   rkIdx [2];

  logic [127:0] fipsRk [15];
  logic [127:0] zeroRk [4];
  logic [127:0] expRk [15];

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int validCycles;
  int lastBeat;

  always #5 clk = ~clk;

  aes256_key_schedule_iter #(.SBOX_REG(0)) dut0 (
    .clk(clk), .rst(rst), .key_valid(keyValid[0]), .key_ready(keyReady[0]), .key(key),
    .rk_valid(rkValid[0]), .rk_ready(rkReady[0]), .rk_data(rkData[0]), .rk_idx(rkIdx[0]),
    .rk_last(rkLast[0]), .busy(busy[0])
  );

  aes256_key_schedule_iter #(.SBOX_REG(1)) dut1 (
    .clk(clk), .rst(rst), .key_valid(keyValid[1]), .key_ready(keyReady[1]), .key(key),
    .rk_valid(rkValid[1]), .rk_ready(rkReady[1]), .rk_data(rkData[1]), .rk_idx(rkIdx[1]),
    .rk_last(rkLast[1]), .busy(busy[1])
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer a key for one clock edge; returns just after the accepting edge
  task automatic applyStimulus(input int sel, input logic [255:0] k);
    key           = k;
    keyValid[sel] = 1'b1;
    @(posedge clk);
    #1;
    keyValid[sel] = 1'b0;
  endtask

  task automatic loadExpected(input bit useZero);
    for (int i = 0; i < 15; i++) expRk[i] = fipsRk[i];
    if (useZero) for (int i = 0; i < 4; i++) expRk[i] = zeroRk[i];
  endtask

  // Collect nBeats handshakes, checking data/idx/last on every valid cycle (covers stalls)
  task automatic runStream(input int sel, input bit randReady, input bit interfere,
                           input int nBeats, output int nValid, output int lastCycle);
    int beats = 0;
    int cycle = 0;
    nValid    = 0;
    lastCycle = 0;
    while (beats < nBeats && cycle < 200) begin
      rkReady[sel] = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (interfere && cycle == 3) begin
        key           = KEY_ZERO;
        keyValid[sel] = 1'b1;
      end
      @(negedge clk);
      cycle++;
      if (interfere && cycle == 4)
        checkOutput("key_ready_during_stream", 128'(keyReady[sel]), 128'd0);
      if (rkValid[sel]) begin
        nValid++;
        checkOutput($sformatf("dut%0d rk_data[%0d]", sel, beats), rkData[sel], expRk[beats]);
        checkOutput($sformatf("dut%0d rk_idx[%0d]", sel, beats), 128'(rkIdx[sel]), 128'(beats));
        checkOutput($sformatf("dut%0d rk_last[%0d]", sel, beats), 128'(rkLast[sel]),
                    128'(beats == 14));
        if (rkReady[sel]) begin
          beats++;
          lastCycle = cycle;
        end
      end
      @(posedge clk);
      #1;
    end
    rkReady[sel] = 1'b0;
    checkOutput($sformatf("dut%0d stream_beats", sel), 128'(beats), 128'(nBeats));
  endtask

  task automatic checkIdleAfter(input int sel, input string tag);
    @(negedge clk);
    checkOutput({tag, " rk_valid"}, 128'(rkValid[sel]), 128'd0);
    checkOutput({tag, " busy"}, 128'(busy[sel]), 128'd0);
    checkOutput({tag, " key_ready"}, 128'(keyReady[sel]), 128'd1);
  endtask

  initial begin
    fipsRk[0]  = 128'h603deb1015ca71be2b73aef0857d7781;
    fipsRk[1]  = 128'h1f352c073b6108d72d9810a30914dff4;
    fipsRk[2]  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    fipsRk[3]  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
    fipsRk[4]  = 128'hd59aecb85bf3c917fee94248de8ebe96;
    fipsRk[5]  = 128'hb5a9328a2678a647983122292f6c79b3;
    fipsRk[6]  = 128'h812c81addadf48ba24360af2fab8b464;
    fipsRk[7]  = 128'h98c5bfc9bebd198e268c3ba709e04214;
    fipsRk[8]  = 128'h68007bacb2df331696e939e46c518d80;
    fipsRk[9]  = 128'hc814e20476a9fb8a5025c02d59c58239;
    fipsRk[10] = 128'hde1369676ccc5a71fa2563959674ee15;
    fipsRk[11] = 128'h5886ca5d2e2f31d77e0af1fa27cf73c3;
    fipsRk[12] = 128'h749c47ab18501ddae2757e4f7401905a;
    fipsRk[13] = 128'hcafaaae3e4d59b349adf6acebd10190d;
    fipsRk[14] = 128'hfe4890d1e6188d0b046df344706c631e;
    zeroRk[0]  = 128'h0;
    zeroRk[1]  = 128'h0;
    zeroRk[2]  = 128'h62636363626363636263636362636363;
    zeroRk[3]  = 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb;

    rst      = 1'b1;
    key      = '0;
    keyValid = 2'b00;
    rkReady  = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset rk_valid", 128'(rkValid[0]), 128'd0);
    checkOutput("reset busy", 128'(busy[0]), 128'd0);
    checkOutput("reset rk_idx", 128'(rkIdx[0]), 128'd0);
    checkOutput("reset rk_data", rkData[0], 128'd0);
    checkOutput("reset rk_last", 128'(rkLast[0]), 128'd0);
    checkOutput("reset dut1 busy", 128'(busy[1]), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("key_ready after reset dut0", 128'(keyReady[0]), 128'd1);
    checkOutput("key_ready after reset dut1", 128'(keyReady[1]), 128'd1);

    $display("[TB] FIPS key, SBOX_REG=0, rk_ready held high");
    loadExpected(1'b0);
    applyStimulus(0, KEY_FIPS);
    runStream(0, 1'b0, 1'b0, 15, validCycles, lastBeat);
    checkOutput("dut0 valid_cycles", 128'(validCycles), 128'd15);
    checkOutput("dut0 last_beat_cycle", 128'(lastBeat), 128'd15);
    checkIdleAfter(0, "dut0 post-stream");

    $display("[TB] FIPS key, SBOX_REG=0, random rk_ready");
    applyStimulus(0, KEY_FIPS);
    runStream(0, 1'b1, 1'b0, 15, validCycles, lastBeat);
    checkIdleAfter(0, "dut0 post-random");

    $display("[TB] FIPS key, SBOX_REG=1, rk_ready held high");
    applyStimulus(1, KEY_FIPS);
    runStream(1, 1'b0, 1'b0, 15, validCycles, lastBeat);
    checkOutput("dut1 valid_cycles", 128'(validCycles), 128'd15);
    checkOutput("dut1 last_beat_cycle", 128'(lastBeat), 128'd29);
    checkIdleAfter(1, "dut1 post-stream");

    $display("[TB] second key offered mid-stream, then all-zero key stream");
    applyStimulus(0, KEY_FIPS);
    runStream(0, 1'b0, 1'b1, 15, validCycles, lastBeat);
    @(negedge clk);
    checkOutput("bubble rk_valid", 128'(rkValid[0]), 128'd0);
    checkOutput("bubble key_ready", 128'(keyReady[0]), 128'd1);
    @(posedge clk);
    #1;
    keyValid[0] = 1'b0;
    loadExpected(1'b1);
    runStream(0, 1'b0, 1'b0, 4, validCycles, lastBeat);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset while rk_idx = 7");
    loadExpected(1'b0);
    applyStimulus(0, KEY_FIPS);
    runStream(0, 1'b0, 1'b0, 7, validCycles, lastBeat);
    @(negedge clk);
    checkOutput("pre-reset rk_idx", 128'(rkIdx[0]), 128'd7);
    checkOutput("pre-reset rk_valid", 128'(rkValid[0]), 128'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkIdleAfter(0, "dut0 after mid reset");
    applyStimulus(0, KEY_FIPS);
    runStream(0, 1'b1, 1'b0, 15, validCycles, lastBeat);
    checkIdleAfter(0, "dut0 post-restart");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
